// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, halt encoding, fetch FSM state type and a
//               saturating-increment helper for the fetch stage, control
//               decoder and instruction ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int PC_W   = 10;
  localparam int INST_W = 9;
  localparam int KEY_W  = 5;
  localparam int CNT_W  = 16;

  // Branch-group opcode 111 with an all-ones key; the decoder never issues it.
  localparam logic [INST_W-1:0] HALT_INST = 9'b1_111_11111;

  // Last ROM address; reaching it without a branch or halt is a fault.
  localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's program, ROM, decoder and branch
//               LUT signals. The slave modport is the fetch unit itself; the
//               master modport is the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic [INST_W-1:0] inst_in;
  logic              branch_en;
  logic              lut_we;
  logic [KEY_W-1:0]  lut_addr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic              run;
  logic              done;
  logic              fault;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, start_pc, inst_in, branch_en, lut_we, lut_addr, lut_wdata,
    input  pc, inst, run, done, fault, cycle_count
  );

  modport slave (
    input  start, start_pc, inst_in, branch_en, lut_we, lut_addr, lut_wdata,
    output pc, inst, run, done, fault, cycle_count
  );

endinterface
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut
// Description : Branch target table. 2^KEY_W entries of DATA_W bits with a
//               synchronous write port, a combinational read port and an
//               asynchronous clear to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_lut #(
  parameter int KEY_W  = 5,
  parameter int DATA_W = 10
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              we,
  input  wire logic [KEY_W-1:0]  waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [KEY_W-1:0]  raddr,
  output logic      [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** KEY_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Table storage: cleared on reset, one entry written per enabled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Target lookup is combinational so a branch resolves in the cycle it is seen.
  always_comb begin
    rdata = r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program counter and instruction fetch stage. Runs a program
//               from start_pc until a halt instruction or PC overflow,
//               resolving branches through the branch LUT and counting the
//               cycles spent running.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
(
  input wire logic     clk,
  input wire logic     reset,
  fetch_unit_if.slave  bus
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fault;
  logic             w_fault_nxt;
  logic             w_run;
  logic             w_lut_we;
  logic [PC_W-1:0]  w_lut_rdata;

  // Run flag and LUT write gating: the table is frozen while a program runs.
  always_comb begin
    w_run    = (r_state == RUN);
    w_lut_we = bus.lut_we & ~w_run;
  end

  branch_lut #(
    .KEY_W  (KEY_W),
    .DATA_W (PC_W)
  ) u_branch_lut (
    .clk   (clk),
    .reset (reset),
    .we    (w_lut_we),
    .waddr (bus.lut_addr),
    .wdata (bus.lut_wdata),
    .raddr (bus.inst_in[KEY_W-1:0]),
    .rdata (w_lut_rdata)
  );

  // State, PC, cycle counter and fault flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state logic: halt beats branch beats overflow beats sequential fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    case (r_state)
      RUN: begin
        w_cnt_nxt = sat_inc(r_cnt);
        if (bus.inst_in == HALT_INST) begin
          w_state_nxt = DONE;
        end else if (bus.branch_en) begin
          w_pc_nxt = w_lut_rdata;
        end else if (r_pc == PC_LAST) begin
          w_state_nxt = DONE;
          w_fault_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new program; start during RUN is ignored.
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = bus.start_pc;
          w_cnt_nxt   = '0;
          w_fault_nxt = 1'b0;
        end
      end
    endcase
  end

  // Outputs; outside RUN the decoder sees a halt so it stays idle.
  assign bus.pc          = r_pc;
  assign bus.inst        = w_run ? bus.inst_in : HALT_INST;
  assign bus.run         = w_run;
  assign bus.done        = (r_state == DONE);
  assign bus.fault       = r_fault;
  assign bus.cycle_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural program
//               interpreter (ROM array + LUT array) predicts the PC trace,
//               cycle count and fault outcome of each program.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [INST_W-1:0] rom   [0:1023];
  logic [PC_W-1:0]   lut_m [0:31];
  logic              force_br = 1'b0;

  // Combinational ROM and a minimal decoder: opcode 110 is a branch.
  assign bus.inst_in   = rom[bus.pc];
  assign bus.branch_en = force_br | (bus.inst[8:6] == 3'b110);

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  function automatic logic [INST_W-1:0] br(input logic [4:0] key);
    return {3'b110, 1'b0, key};
  endfunction

  function automatic logic [INST_W-1:0] nop(input int idx);
    logic [5:0] low;
    low = idx[5:0];
    return {3'b000, low};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program interpreter: fills exp_q with the PC of every RUN cycle.
  function automatic void model(input int spc, input int cap, output bit flt, output bit ended);
    int p;
    logic [INST_W-1:0] w;
    exp_q.delete();
    p     = spc;
    flt   = 1'b0;
    ended = 1'b0;
    while (exp_q.size() < cap) begin
      exp_q.push_back(p);
      w = rom[p];
      if (w == HALT_INST) begin
        ended = 1'b1;
        return;
      end
      if (w[8:6] == 3'b110) begin
        p = int'(lut_m[w[4:0]]);
      end else if (p == 1023) begin
        flt   = 1'b1;
        ended = 1'b1;
        return;
      end else begin
        p = p + 1;
      end
    end
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 32; k++) lut_m[k] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
    bus.lut_we    = 1'b1;
    bus.lut_addr  = a;
    bus.lut_wdata = d;
    @(posedge clk);
    #1;
    bus.lut_we = 1'b0;
    lut_m[a]   = d;
  endtask

  // Start a program and follow it cycle by cycle against the interpreter.
  task automatic run_prog(input string tag, input logic [9:0] spc, input int cap,
                          input bit we_run, input bit we_start,
                          input logic [4:0] wa, input logic [9:0] wd, input bit start_run);
    bit flt, ended;
    int n;
    if (we_start) lut_m[wa] = wd;
    model(int'(spc), cap, flt, ended);
    n = exp_q.size();
    bus.start    = 1'b1;
    bus.start_pc = spc;
    if (we_start) begin
      bus.lut_we    = 1'b1;
      bus.lut_addr  = wa;
      bus.lut_wdata = wd;
    end
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.lut_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"}, 32'(bus.pc), exp_q[i]);
      chk({tag, "_run"}, 32'(bus.run), 1);
      chk({tag, "_done_low"}, 32'(bus.done), 0);
      chk({tag, "_cnt"}, 32'(bus.cycle_count), i);
      chk({tag, "_inst"}, 32'(bus.inst), 32'(rom[exp_q[i]]));
      if (i == 0 && we_run) begin
        bus.lut_we    = 1'b1;
        bus.lut_addr  = wa;
        bus.lut_wdata = wd;
      end
      if (i == 1) begin
        bus.lut_we = 1'b0;
        if (start_run) begin
          bus.start    = 1'b1;
          bus.start_pc = 10'd100;
        end
      end
      if (i == 2) bus.start = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.lut_we = 1'b0;
    bus.start  = 1'b0;
    if (ended) begin
      chk({tag, "_end_done"}, 32'(bus.done), 1);
      chk({tag, "_end_run"}, 32'(bus.run), 0);
      chk({tag, "_end_fault"}, 32'(bus.fault), 32'(flt));
      chk({tag, "_end_pc"}, 32'(bus.pc), exp_q[n-1]);
      chk({tag, "_end_cnt"}, 32'(bus.cycle_count), n);
      chk({tag, "_end_inst"}, 32'(bus.inst), 32'(HALT_INST));
    end else begin
      chk({tag, "_cap_run"}, 32'(bus.run), 1);
      chk({tag, "_cap_cnt"}, 32'(bus.cycle_count), n);
      do_reset();
    end
  endtask

  initial begin : stimulus
    bit found;
    logic [9:0] pc_hold;
    bus.start     = 1'b0;
    bus.start_pc  = '0;
    bus.lut_we    = 1'b0;
    bus.lut_addr  = '0;
    bus.lut_wdata = '0;
    for (int a = 0; a < 1024; a++) rom[a] = nop(a);
    for (int k = 0; k < 32; k++) lut_m[k] = '0;

    #1 reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_run", 32'(bus.run), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_cnt", 32'(bus.cycle_count), 0);
    chk("rst_inst", 32'(bus.inst), 32'(HALT_INST));

    // Straight-line program 0..4.
    rom[4] = HALT_INST;
    run_prog("line", 10'd0, 50, 0, 0, '0, '0, 0);

    // Branch on key 3 to address 10.
    lut_write(5'd3, 10'd10);
    rom[2]  = br(5'd3);
    rom[10] = HALT_INST;
    run_prog("branch", 10'd0, 50, 0, 0, '0, '0, 0);
    rom[2] = nop(2);

    // Branch outside RUN does nothing.
    pc_hold  = bus.pc;
    force_br = 1'b1;
    @(posedge clk);
    #1;
    force_br = 1'b0;
    chk("idle_br_pc", 32'(bus.pc), 32'(pc_hold));
    chk("idle_br_done", 32'(bus.done), 1);

    // PC overflow at the top of the ROM.
    run_prog("ovf", 10'd1021, 50, 0, 0, '0, '0, 0);

    // LUT write during RUN dropped; write coincident with start committed.
    rom[22] = br(5'd5);
    rom[7]  = HALT_INST;
    run_prog("lut_run", 10'd20, 50, 1, 0, 5'd5, 10'd7, 0);
    run_prog("lut_start", 10'd20, 50, 0, 1, 5'd5, 10'd7, 0);

    // Asynchronous reset in the middle of a program.
    bus.start    = 1'b1;
    bus.start_pc = 10'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.pc == 10'd3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("midrst_reach", 32'(found), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_pc", 32'(bus.pc), 0);
    chk("midrst_run", 32'(bus.run), 0);
    chk("midrst_cnt", 32'(bus.cycle_count), 0);
    chk("midrst_done", 32'(bus.done), 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 32; k++) lut_m[k] = '0;
    @(posedge clk);
    #1;
    rom[50] = br(5'd3);
    run_prog("lut_cleared", 10'd50, 50, 0, 0, '0, '0, 0);

    // Restart from DONE at 8, with a start pulse during RUN ignored.
    run_prog("restart", 10'd8, 50, 0, 0, '0, '0, 1);

    // Randomized programs.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 1024; a++) begin
        rom[a] = ($urandom_range(99) < 8) ? HALT_INST : INST_W'($urandom);
      end
      for (int k = 0; k < 6; k++) begin
        lut_write(5'($urandom), 10'($urandom));
      end
      run_prog("rand", 10'($urandom), 150, 0, 0, '0, '0, ($urandom_range(1) == 1));
    end

    // Cycle counter saturation on a self-loop.
    rom[600] = br(5'd7);
    lut_write(5'd7, 10'd600);
    bus.start    = 1'b1;
    bus.start_pc = 10'd600;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(bus.cycle_count), 32'hFFFF);
    chk("sat_run", 32'(bus.run), 1);
    chk("sat_pc", 32'(bus.pc), 600);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage sitting directly upstream of the control decoder.
- Presents the current PC to the combinational instruction ROM and forwards the returned 9-bit instruction to the decoder.
- Consumes the decoder's branch_en and resolves branch targets through a 32-entry branch lookup table indexed by inst[4:0].
- Owns the program-level start/done handshake, halt detection, PC-overflow fault, and a run-cycle counter.

Parameters:
- PC_W, 10, program counter width (instruction ROM depth 2^PC_W).
- INST_W, 9, instruction width.
- KEY_W, 5, branch-key width; the LUT has 2^KEY_W entries.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled start request.
- start_pc  in  PC_W  PC loaded on accepted start.
- inst_in  in  INST_W  instruction ROM read data for address pc (combinational ROM).
- branch_en  in  1  from control decoder; take branch this cycle.
- lut_we  in  1  branch LUT write enable.
- lut_addr  in  KEY_W  branch LUT write index.
- lut_wdata  in  PC_W  branch LUT write data (target PC).
- pc  out  PC_W  current PC, drives instruction ROM address.
- inst  out  INST_W  instruction to control decoder.
- run  out  1  high while executing; downstream gates register and memory writes with it.
- done  out  1  program finished (halt or fault).
- fault  out  1  PC ran off end of ROM.
- cycle_count  out  CNT_W  RUN cycles of the last/current program.

Behaviour:
- Reset is asynchronous and active-high. While asserted: state=IDLE, pc=0, run=0, done=0, fault=0, cycle_count=0, all LUT entries=0.
- inst: equals inst_in when run=1, else HALT_INST. This makes the decoder idle outside RUN.
- HALT_INST = 9'b1_111_11111 (branch-group opcode 111, unused by the decoder).
- States:
  - IDLE: run=0, done=0.
  - RUN: run=1.
  - DONE: run=0, done=1.
- IDLE/DONE -> RUN: start=1 at an edge. Same edge: pc<=start_pc, cycle_count<=0, fault<=0, done<=0.
- RUN, each edge, in priority order:
  1. inst_in==HALT_INST -> DONE; pc holds.
  2. branch_en=1 -> pc<=lut[inst_in[KEY_W-1:0]].
  3. pc==2^PC_W-1 -> DONE, fault<=1; pc holds (no wrap to 0).
  4. Otherwise pc<=pc+1.
- cycle_count increments on every edge spent in RUN, including the halting cycle. It saturates at all-ones.
- start while in RUN is ignored.
- Branch latency: target PC is visible one cycle after the branch instruction is presented. No delay slots, no bubbles.
- LUT:
  - Combinational read, synchronous write.
  - Writes are accepted only when run=0; lut_we during RUN is dropped.
  - lut_we and start on the same edge: the write commits, and the first RUN cycle sees the new entry.
- Reset asserted mid-RUN: immediate return to IDLE with all reset values; the in-flight instruction is abandoned.
- branch_en sampled outside RUN has no effect.

Decomposition:
- Shared package fetch_pkg:
  - HALT_INST constant.
  - fetch_state_t enum {IDLE, RUN, DONE}.
  - Width constants PC_W, KEY_W, CNT_W, shared with the control decoder and instruction ROM.
- One sub-module, branch_lut:
  - 2^KEY_W x PC_W register array with write port (we, waddr, wdata) and combinational read port (raddr -> rdata).
  - Async reset to zero.
- fetch_unit holds the FSM, PC, counter and output muxing.

Test Plan:
- Straight-line program: ROM 0..3 = non-branch opcodes, ROM[4]=HALT_INST; start_pc=0, start pulse -> pc 0,1,2,3,4 on consecutive cycles; done=1 the cycle after pc=4; cycle_count=5; fault=0.
- Branch: LUT[3]=10 written in IDLE; ROM[2]=unconditional branch key 3 (decoder branch_en=1); ROM[10]=HALT_INST -> pc sequence 0,1,2,10; done set; cycle_count=4.
- Overflow: start_pc=1021, ROM[1021..1023] non-branch, non-halt -> pc 1021,1022,1023 then DONE with fault=1, pc holds 1023.
- LUT write gating: lut_we with lut_addr=5, lut_wdata=7 during RUN, then a branch on key 5 -> pc goes to the prior entry (0), not 7. Same write in IDLE coincident with start -> branch goes to 7.
- Reset mid-run: assert reset asynchronously at pc=3 (between edges) -> pc=0, run=0, cycle_count=0 immediately. LUT cleared, so a branch after restart goes to 0.
- Restart from DONE and ignored start: start in DONE with start_pc=8 -> done drops, run=1, pc=8, cycle_count restarts at 0. start pulse while in RUN -> no change to pc or cycle_count.
